// File: rtl/cdc_bus_arbiter_if.sv
// Requester and cdc_bus source-side signals shared by the arbiter and its users.
//   req_i          per-requester request level, held until the matching ack
//   req_data_i     packed requester words, requester k at [k*pDATA_WIDTH +: pDATA_WIDTH]
//   req_ack_o      one-hot, one-cycle acceptance strobe
//   cdc_pulse_o    launch pulse to cdc_bus src_pulse
//   cdc_data_o     launch data to cdc_bus src_data
//   cdc_overflow_i cdc_bus src_overflow
// slave  = arbiter side, master = requesters / channel side.
interface cdc_bus_arbiter_if #(
  parameter int unsigned pNUM_REQ    = 4,
  parameter int unsigned pDATA_WIDTH = 8
);
  logic [pNUM_REQ-1:0]             req_i;
  logic [pNUM_REQ*pDATA_WIDTH-1:0] req_data_i;
  logic [pNUM_REQ-1:0]             req_ack_o;
  logic                            cdc_pulse_o;
  logic [pDATA_WIDTH-1:0]          cdc_data_o;
  logic                            cdc_overflow_i;

  modport slave (
    input  req_i, req_data_i, cdc_overflow_i,
    output req_ack_o, cdc_pulse_o, cdc_data_o
  );

  modport master (
    output req_i, req_data_i, cdc_overflow_i,
    input  req_ack_o, cdc_pulse_o, cdc_data_o
  );
endinterface

// File: rtl/cdc_bus_arbiter.sv
// Round-robin scheduler sharing one cdc_bus channel among pNUM_REQ requesters.
// Each launch is a single-cycle pulse plus captured data, followed by a
// programmable quiet gap; a channel overflow report parks the block in HALT.
// Ports:
//   clk, reset_n     source-domain clock, async active-low reset
//   bus              requester / cdc_bus handshake signals (slave modport)
//   cfg_gap_i        quiet cycles after each launch (0 behaves as 1)
//   error_clear_i    request to leave HALT
//   grant_id_o       index of the last granted requester
//   busy_o           high in any state other than IDLE
//   error_o          high while in HALT
//   launch_count_o   launches since reset, wraps modulo 2^16
module cdc_bus_arbiter #(
  parameter int unsigned pNUM_REQ    = 4,
  parameter int unsigned pDATA_WIDTH = 8,
  parameter int unsigned pGAP_WIDTH  = 6
) (
  input  logic                        clk,
  input  logic                        reset_n,
  cdc_bus_arbiter_if.slave            bus,
  input  logic [pGAP_WIDTH-1:0]       cfg_gap_i,
  input  logic                        error_clear_i,
  output logic [$clog2(pNUM_REQ)-1:0] grant_id_o,
  output logic                        busy_o,
  output logic                        error_o,
  output logic [15:0]                 launch_count_o
);

  localparam int unsigned IDW  = $clog2(pNUM_REQ);
  localparam int unsigned CNTW = 16;
  localparam logic [IDW-1:0] PTR_RST = IDW'(pNUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_GAP    = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [IDW-1:0]          r_ptr;
  logic [IDW-1:0]          r_grant;
  logic [pGAP_WIDTH-1:0]   r_gap_cnt;
  logic [CNTW-1:0]         r_count;
  logic [pDATA_WIDTH-1:0]  r_data;
  logic [pNUM_REQ-1:0]     r_ack;
  logic                    r_pulse;
  logic                    r_busy;
  logic                    r_error;

  logic                    w_any;
  logic [IDW-1:0]          w_winner;
  logic [IDW-1:0]          w_idx;
  logic [IDW-1:0]          w_ptr_nxt;
  logic [IDW-1:0]          w_grant_nxt;
  logic [pGAP_WIDTH-1:0]   w_gap_nxt;
  logic [CNTW-1:0]         w_count_nxt;
  logic [pDATA_WIDTH-1:0]  w_data_nxt;
  logic [pNUM_REQ-1:0]     w_ack_nxt;
  logic                    w_pulse_nxt;
  logic                    w_busy_nxt;
  logic                    w_error_nxt;

  // Round-robin pick: first pending request scanning upward from r_ptr+1 with wrap.
  always_comb begin : pick_winner
    w_any    = 1'b0;
    w_winner = r_ptr;
    w_idx    = '0;
    for (int unsigned i = 1; i <= pNUM_REQ; i++) begin
      w_idx = IDW'((32'(r_ptr) + i) % pNUM_REQ);
      if (!w_any && bus.req_i[w_idx]) begin
        w_any    = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin : state_reg
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= PTR_RST;
      r_grant   <= '0;
      r_gap_cnt <= '0;
      r_count   <= '0;
      r_data    <= '0;
      r_ack     <= '0;
      r_pulse   <= 1'b0;
      r_busy    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_grant   <= w_grant_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_count   <= w_count_nxt;
      r_data    <= w_data_nxt;
      r_ack     <= w_ack_nxt;
      r_pulse   <= w_pulse_nxt;
      r_busy    <= w_busy_nxt;
      r_error   <= w_error_nxt;
    end
  end

  // Next-state logic; overflow always wins over launching or finishing a gap.
  always_comb begin : next_state
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.cdc_overflow_i) begin
          w_state_nxt = ST_HALT;
        end else if (w_any) begin
          w_state_nxt = ST_LAUNCH;
        end
      end
      ST_LAUNCH: w_state_nxt = ST_GAP;
      ST_GAP: begin
        if (bus.cdc_overflow_i) begin
          w_state_nxt = ST_HALT;
        end else if (r_gap_cnt <= pGAP_WIDTH'(1)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HALT: begin
        if (error_clear_i && !bus.cdc_overflow_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values for the output and datapath registers.
  always_comb begin : output_next
    w_pulse_nxt = 1'b0;
    w_ack_nxt   = '0;
    w_data_nxt  = r_data;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_gap_nxt   = r_gap_cnt;
    w_count_nxt = r_count;
    w_busy_nxt  = (w_state_nxt != ST_IDLE);
    w_error_nxt = (w_state_nxt == ST_HALT);

    // Capture the winner on entry to LAUNCH so pulse, ack and data appear together.
    if (r_state == ST_IDLE && w_state_nxt == ST_LAUNCH) begin
      w_pulse_nxt          = 1'b1;
      w_ack_nxt[w_winner]  = 1'b1;
      w_data_nxt           = bus.req_data_i[32'(w_winner) * pDATA_WIDTH +: pDATA_WIDTH];
      w_grant_nxt          = w_winner;
      w_ptr_nxt            = w_winner;
    end

    // Gap length is sampled only while LAUNCH is active; zero is stretched to one.
    if (r_state == ST_LAUNCH) begin
      w_count_nxt = r_count + CNTW'(1);
      w_gap_nxt   = (cfg_gap_i == '0) ? pGAP_WIDTH'(1) : cfg_gap_i;
    end else if (r_state == ST_GAP && r_gap_cnt != '0) begin
      w_gap_nxt = r_gap_cnt - pGAP_WIDTH'(1);
    end
  end

  assign bus.cdc_pulse_o = r_pulse;
  assign bus.cdc_data_o  = r_data;
  assign bus.req_ack_o   = r_ack;
  assign grant_id_o      = r_grant;
  assign busy_o          = r_busy;
  assign error_o         = r_error;
  assign launch_count_o  = r_count;

endmodule
